// File: rtl/mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mux_rr_arbiter
// Brief    : Round-robin N:1 valid/ready arbiter with one registered output beat.
//            Define MUX_RR_ARB_PACKET_LOCK_EN to hold the grant for a whole packet.
// Revision : 1.0 - initial release
// ============================================================================
module mux_rr_arbiter #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [N*W-1:0]   in_data,
    input  logic [N-1:0]     in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDW-1:0]   out_id,
    output logic             out_last
);

    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_data_q, out_data_d;
    logic [IDW-1:0]   out_id_q, out_id_d;
    logic             out_last_q, out_last_d;
    logic [IDW-1:0]   ptr_q, ptr_d;

    logic [N-1:0]     w_eligible;
    logic             w_free;
    logic             w_found;
    logic             w_handshake;
    logic             w_ptr_adv;
    logic [IDW:0]     w_idx;
    logic [IDW-1:0]   w_grant;
    logic [IDW-1:0]   w_grant_inc;
    logic [W-1:0]     w_sel_data;
    logic             w_sel_last;

    assign w_free = !out_valid_q || out_ready;

`ifdef MUX_RR_ARB_PACKET_LOCK_EN
    logic             lock_q, lock_d;
    logic [IDW-1:0]   locked_id_q, locked_id_d;

    always_comb begin
        w_eligible = in_valid;
        if (lock_q) begin
            w_eligible = in_valid & ({{(N-1){1'b0}}, 1'b1} << locked_id_q);
        end
    end

    // A packet only counts as one turn, so the pointer moves on its last beat.
    assign w_ptr_adv = w_sel_last;

    always_comb begin
        lock_d      = lock_q;
        locked_id_d = locked_id_q;
        if (w_handshake) begin
            lock_d      = !w_sel_last;
            locked_id_d = w_grant;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_q      <= 1'b0;
            locked_id_q <= '0;
        end else begin
            lock_q      <= lock_d;
            locked_id_q <= locked_id_d;
        end
    end
`else
    assign w_eligible = in_valid;
    assign w_ptr_adv  = 1'b1;
`endif

    // Scan ptr, ptr+1, ... wrapping modulo N; first eligible index wins.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = {1'b0, ptr_q} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(N)) begin
                w_idx = w_idx - (IDW+1)'(N);
            end
            if (!w_found && w_eligible[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (w_grant == IDW'(i)) begin
                w_sel_data = in_data[i*W +: W];
                w_sel_last = in_last[i];
            end
        end
    end

    assign w_grant_inc = (w_grant == IDW'(N-1)) ? '0 : w_grant + IDW'(1);
    assign w_handshake = w_free && w_found;

    always_comb begin
        in_ready = '0;
        if (rst_n && w_handshake) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_id_d    = out_id_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;
        if (w_handshake) begin
            out_valid_d = 1'b1;
            out_data_d  = w_sel_data;
            out_id_d    = w_grant;
            out_last_d  = w_sel_last;
            if (w_ptr_adv) begin
                ptr_d = w_grant_inc;
            end
        end else if (w_free) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_id_q    <= '0;
            out_last_q  <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_id_q    <= out_id_d;
            out_last_q  <= out_last_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_rr_arbiter
// Brief    : Scoreboard bench for mux_rr_arbiter against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_rr_arbiter;

    localparam int N   = 4;
    localparam int W   = 8;
    localparam int IDW = $clog2(N);

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [W-1:0]   data;
        logic           last;
    } beat_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [N-1:0]     in_valid = '0;
    logic [N-1:0]     in_ready;
    logic [N*W-1:0]   in_data = '0;
    logic [N-1:0]     in_last = '0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [W-1:0]     out_data;
    logic [IDW-1:0]   out_id;
    logic             out_last;

    int     n_checks = 0;
    int     n_fail   = 0;
    beat_t  sb_q[$];
    int     id_log[$];

    // Reference state: whether a beat is held, turn pointer, packet lock.
    logic         m_ov = 1'b0;
    int           m_ptr = 0;
    logic         m_lock = 1'b0;
    int           m_lid = 0;
    logic [N-1:0] hs_mask = '0;

    mux_rr_arbiter #(.N(N), .W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ov   = 1'b0;
        m_ptr  = 0;
        m_lock = 1'b0;
        m_lid  = 0;
        sb_q.delete();
    endtask

    function automatic void model_grant(output bit found, output int g);
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N; k++) begin
            int j  = (m_ptr + k) % N;
            bit ok = in_valid[j];
`ifdef MUX_RR_ARB_PACKET_LOCK_EN
            if (m_lock && j != m_lid) ok = 1'b0;
`endif
            if (ok && !found) begin
                found = 1'b1;
                g     = j;
            end
        end
    endfunction

    function automatic logic [N-1:0] model_ready();
        bit           f;
        int           g;
        logic [N-1:0] r = '0;
        model_grant(f, g);
        if (rst_n && f && (!m_ov || out_ready)) r[g] = 1'b1;
        return r;
    endfunction

    // Applied at each rising edge using the inputs that were stable before it.
    task automatic model_step();
        bit f;
        int g;
        bit free;
        hs_mask = '0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        free = !m_ov || out_ready;
        model_grant(f, g);
        if (f && free) begin
            hs_mask[g] = 1'b1;
            sb_q.push_back(beat_t'{IDW'(g), in_data[g*W +: W], in_last[g]});
            m_ov = 1'b1;
`ifdef MUX_RR_ARB_PACKET_LOCK_EN
            if (in_last[g]) begin
                m_ptr  = (g + 1) % N;
                m_lock = 1'b0;
            end else begin
                m_lock = 1'b1;
                m_lid  = g;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (free) begin
            m_ov = 1'b0;
        end
    endtask

    // Monitor: compares the presented beat with the scoreboard head.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL scoreboard_empty: got out_id 0x%0h expected no beat at %0t", out_id, $time);
                end else begin
                    chk("out_id",   32'(out_id),   32'(sb_q[0].id));
                    chk("out_data", 32'(out_data), 32'(sb_q[0].data));
                    chk("out_last", 32'(out_last), 32'(sb_q[0].last));
                    if (out_ready) begin
                        id_log.push_back(int'(out_id));
                        void'(sb_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic check_ready();
        #1;
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    // seq holds one expected id per nibble, first beat in the lowest nibble.
    task automatic check_log(input string name, input int len, input logic [31:0] seq);
        n_checks++;
        if (id_log.size() < len) begin
            n_fail++;
            $display("FAIL %s_len: got %0d beats expected at least %0d", name, id_log.size(), len);
        end
        for (int i = 0; i < len; i++) begin
            if (i < id_log.size()) chk(name, 32'(id_log[i]), 32'(seq[4*i +: 4]));
        end
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_id",    32'(out_id),    32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        repeat (2) cycle();
        rst_n = 1'b1;
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        check_ready();
        repeat (2) cycle();
        settle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        model_reset();
        repeat (3) cycle();
        chk("init_out_valid", 32'(out_valid), 32'd0);
        chk("init_out_data",  32'(out_data),  32'd0);
        chk("init_in_ready",  32'(in_ready),  32'd0);
        rst_n = 1'b1;

        // Fairness: all requesters valid, consumer always ready.
        in_data   = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        in_last   = '1;
        in_valid  = '1;
        out_ready = 1'b1;
        id_log.delete();
        check_ready();
        repeat (5) begin
            cycle();
            check_ready();
        end
        settle();
        check_log("fair_order", 5, 32'h0003210);
        drain();

        // Single requester streams every cycle.
        in_valid = 4'b0100;
        id_log.delete();
        check_ready();
        repeat (4) begin
            cycle();
            check_ready();
            chk("req2_ready", 32'(in_ready), 32'h4);
        end
        settle();
        check_log("req2_order", 4, 32'h2222);
        drain();

        // Back-pressure: grant must not move while stalled.
        do_reset();
        in_data   = {8'h00, 8'h00, 8'h11, 8'h10};
        in_valid  = 4'b0011;
        out_ready = 1'b0;
        id_log.delete();
        check_ready();
        cycle();
        check_ready();
        repeat (3) begin
            cycle();
            check_ready();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data",  32'(out_data),  32'h10);
        end
        out_ready = 1'b1;
        check_ready();
        chk("stall_next_ready", 32'(in_ready), 32'h2);
        cycle();
        settle();
        check_log("stall_order", 2, 32'h10);
        drain();

        // Packet of three beats from requester 1 competing with requester 3.
        do_reset();
        in_data   = {8'h73, 8'h00, 8'h51, 8'h00};
        in_last   = 4'b1000;
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        cnt       = 0;
        id_log.delete();
        check_ready();
        repeat (6) begin
            cycle();
            if (hs_mask[1]) begin
                cnt++;
                in_data[15:8] = 8'(8'h51 + cnt);
                in_last[1]    = (cnt == 2);
                if (cnt == 3) in_valid[1] = 1'b0;
            end
            check_ready();
        end
        settle();
`ifdef MUX_RR_ARB_PACKET_LOCK_EN
        check_log("pkt_order", 4, 32'h3111);
`else
        check_log("pkt_order", 4, 32'h3131);
`endif
        drain();

        // Reset while a beat is held and a packet is open.
        in_valid  = 4'b0100;
        in_last   = 4'b0100;
        out_ready = 1'b1;
        check_ready();
        cycle();
        in_valid = 4'b1000;
        in_last  = 4'b0000;
        check_ready();
        cycle();
        out_ready = 1'b0;
        check_ready();
        cycle();
        do_reset();
        in_valid  = 4'b1010;
        out_ready = 1'b1;
        check_ready();
        chk("post_rst_ready", 32'(in_ready), 32'h2);
        cycle();
        drain();

        // Randomized traffic with occasional mid-flight resets.
        in_last = '0;
        for (int c = 0; c < 3000; c++) begin
            cycle();
            if (c % 700 == 350) do_reset();
            for (int i = 0; i < N; i++) begin
                if (hs_mask[i] || !in_valid[i]) begin
                    in_valid[i]       = ($urandom_range(0, 2) != 0);
                    in_data[i*W +: W] = W'($urandom);
                    in_last[i]        = ($urandom_range(0, 2) == 0);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            check_ready();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares one registered W-bit output channel between N valid/ready requesters. Each cycle it selects at most one requester through an N:1 mux tree and captures the selected beat into a single output register. It sits in front of any single-port consumer that must be time-shared, such as a shared bus, a FIFO write port or a serializer. Optional packet locking keeps the grant on one requester until that requester's last beat has been transferred.

## Interface
- N, 4, number of requesters (2..16)
- W, 8, data width in bits
- clk  input  1  clock; all state updates on the rising edge
- rst_n  input  1  asynchronous reset, active low
- in_valid  input  N  per-requester valid; bit i belongs to requester i
- in_ready  output  N  per-requester ready; combinational, at most one bit high (one-hot or zero)
- in_data  input  N*W  requester i data in bits [i*W +: W]
- in_last  input  N  per-requester end-of-packet flag
- out_valid  output  1  output register holds a beat
- out_ready  input  1  consumer accepts the beat
- out_data  output  W  registered data of the granted requester
- out_id  output  $clog2(N)  index of the requester that produced out_data
- out_last  output  1  registered in_last of the granted beat

## Operation
- Output register is free when !out_valid || out_ready.
- Eligible set: all i with in_valid[i]. With packet lock active, the eligible set is only locked_id.
- Grant g: the first eligible index scanning ptr, ptr+1, …, N-1, 0, …, ptr-1, so the scan wraps modulo N.
- in_ready[g] = free && eligible set non-empty. All other in_ready bits are 0.
- When rst_n is low, in_ready is 0 for every requester.
- Input handshake happens when in_valid[g] && in_ready[g]. On that edge:
  - out_data, out_id and out_last load from requester g.
  - out_valid goes to 1.
  - ptr becomes (g+1) mod N.
- Free and no eligible requester: if out_ready was high, out_valid goes to 0; out_data, out_id and out_last hold.
- Not free (out_valid && !out_ready): the register and ptr hold, and every in_ready bit is 0.
- Requesters must hold in_valid and in_data stable until their handshake. The arbiter does not check this.
- Reset values: out_valid=0, out_data=0, out_id=0, out_last=0, ptr=0, lock=0.
- Reset mid-operation clears all state at once. Any beat held in the output register is discarded. An open packet lock is released.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on out_* after edge k.
- Throughput is 1 beat per cycle when out_ready stays high (pass-through on the same edge).
- Arbitration and in_ready are combinational from in_valid, out_valid, out_ready, ptr and lock. There is no register between out_ready and in_ready.
- Fairness: with every requester continuously valid and out_ready=1, the grant order is 0,1,2,…,N-1,0,…
- Simultaneous pop and push: when out_ready=1 and a new grant happen on the same edge, the register is replaced with no bubble.
- The grant changes only on a handshake edge, never while the output is stalled.

## Configuration
- MUX_RR_ARB_PACKET_LOCK_EN defined:
  - After a handshake from requester g with in_last[g]=0, lock is set to 1 and locked_id to g.
  - While lock=1, only locked_id can be granted, even if other requesters are valid.
  - A handshake from locked_id with in_last=1 clears lock.
  - ptr advances only on a handshake whose in_last=1, so a full packet counts as one turn.
- MUX_RR_ARB_PACKET_LOCK_EN undefined:
  - The lock state is not built.
  - ptr advances on every handshake.
  - in_last is carried to out_last only and does not affect arbitration.

## Test plan
- Reset, then all four in_valid held high with data 8'hA0..8'hA3 and out_ready=1 → out_id sequence is 0,1,2,3,0 on consecutive cycles and out_data matches.
- Only requester 2 valid, out_ready=1 → grants on every cycle, and in_ready is 4'b0100 throughout.
- Requesters 0 and 1 valid, out_ready held low for 3 cycles → out_valid stays 1 and out_data stays constant, in_ready is 0; after out_ready rises, the next grant goes to the other requester.
- MUX_RR_ARB_PACKET_LOCK_EN defined: requester 1 sends 3 beats with last on beat 3 while requester 3 is valid → out_id is 1,1,1,3.
- MUX_RR_ARB_PACKET_LOCK_EN undefined, same stimulus → out_id alternates 1,3,1,3.
- rst_n pulsed low mid-packet with out_valid=1 → out_valid=0, out_data=0, in_ready=0 immediately; after release the next grant goes to the lowest-index valid requester (ptr=0).
